debounce_sync: RTL and testbench
================================

// Module: debounce_sync
// PURPOSE
//   Input conditioning stage that sits directly upstream of the D flip-flop stage.
//   Takes a raw asynchronous level (switch or button) and synchronises it to clk.
//   Filters out bounce and drives a clean, glitch-free level onto the flip-flop data input.
//   Also provides single-cycle rise/fall pulses and a count of rejected bounces.
// PARAMETERS
//   SYNC_STAGES      2   synchroniser flops ahead of the filter (legal: >=2)
//   DEBOUNCE_CYCLES  4   consecutive equal samples needed to accept a new level (legal: >=2)
//   BOUNCE_W         8   width of the saturating rejected-bounce counter
// PORTS
//   clk         input   1         rising-edge clock
//   reset       input   1         synchronous, active-high reset
//   din         input   1         raw asynchronous input level
//   q           output  1         debounced level; feeds the flip-flop d input
//   rise        output  1         1-cycle pulse when q goes 0->1
//   fall        output  1         1-cycle pulse when q goes 1->0
//   busy        output  1         1 while a candidate change is being qualified
//   bounce_cnt  output  BOUNCE_W  number of rejected candidates (saturates at all-ones)
// BEHAVIOUR
//   Reset (sampled on a clk rising edge while reset=1):
//     - All synchroniser flops are cleared to 0.
//     - State goes to STABLE_LO and the internal counter cnt goes to 0.
//     - q=0, rise=0, fall=0, busy=0, bounce_cnt=0.
//     - Reset has priority over all other events, including reset asserted mid-qualification.
//   Synchroniser: din_s is din delayed through SYNC_STAGES flops. The FSM uses only din_s.
//   FSM (all actions on the clk rising edge):
//     STABLE_LO:
//       - din_s=1 -> go to CHK_HI, cnt<=1.
//       - otherwise hold.
//     CHK_HI:
//       - din_s=0 -> go to STABLE_LO, cnt<=0, bounce_cnt++.
//       - else if cnt==DEBOUNCE_CYCLES-1 -> go to STABLE_HI, q<=1, rise<=1, cnt<=0.
//       - else cnt++.
//     STABLE_HI: mirror of STABLE_LO, using din_s=0 and going to CHK_LO.
//     CHK_LO: mirror of CHK_HI; on acceptance q<=0 and fall<=1; on rejection go to STABLE_HI.
//   Outputs:
//     - busy is 1 exactly while the state is CHK_HI or CHK_LO. It is registered-state decoded.
//     - rise and fall are registered. Each is high for exactly one cycle and they are never both high.
//   Latency: a clean din step is reflected on q after the (SYNC_STAGES+DEBOUNCE_CYCLES)-th
//     rising edge following the step. With defaults this is the 6th edge.
//   Filtering: any din_s pulse shorter than DEBOUNCE_CYCLES samples never reaches q.
//     Each such pulse increments bounce_cnt by 1.
//   bounce_cnt saturates: when all-ones, a further rejection leaves it unchanged. It has no wrap.
//   cnt width is $clog2(DEBOUNCE_CYCLES). cnt never exceeds DEBOUNCE_CYCLES-1.
//   q changes only on a state transition into STABLE_LO or STABLE_HI. It never toggles on a bounce.
// TESTING (clk period 10, default parameters)
//   1. reset=1 for 2 edges with din=1 -> q=0, busy=0, bounce_cnt=0.
//      After reset=0, q=1 on the 6th edge and rise=1 for that one cycle.
//   2. din steps 0->1 at t=12 and is held -> busy=1 from edge 3 through edge 5.
//      q=1 after edge 6; rise is high for exactly 1 cycle.
//   3. din bounces high for 2 cycles then returns low -> q stays 0, rise never asserts, bounce_cnt=1.
//   4. From q=1, din steps 1->0 and is held -> q=0 after the 6th edge, fall is a 1-cycle pulse.
//   5. reset asserted while busy=1 (in CHK_HI) -> after that edge state is STABLE_LO.
//      Also q=0, busy=0, bounce_cnt=0, and no rise pulse occurs.
//   6. Generate 300 rejected bounces with BOUNCE_W=8 -> bounce_cnt holds at 255 and q stays 0.

Source files
------------

// File: rtl/debounce_sync_if.sv
// Signal bundle between the raw input source and the debounce/sync stage.
interface debounce_sync_if #(
    parameter int unsigned BOUNCE_W = 8
);
    logic                din;
    logic                q;
    logic                rise;
    logic                fall;
    logic                busy;
    logic [BOUNCE_W-1:0] bounce_cnt;

    // Source side: drives the raw level, observes the conditioned result.
    modport master (
        output din,
        input  q,
        input  rise,
        input  fall,
        input  busy,
        input  bounce_cnt
    );

    // Conditioning stage side.
    modport slave (
        input  din,
        output q,
        output rise,
        output fall,
        output busy,
        output bounce_cnt
    );
endinterface

// File: rtl/debounce_sync.sv
// Input conditioning: synchronises a raw asynchronous level to clk, rejects
// bounce shorter than DEBOUNCE_CYCLES samples, and reports edges and the
// number of rejected candidates.
module debounce_sync #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned BOUNCE_W        = 8
) (
    input  logic           clk,
    input  logic           reset,
    debounce_sync_if.slave bus_io
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StStableLo,
        StChkHi,
        StStableHi,
        StChkLo
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   din_s;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   q_q, q_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [BOUNCE_W-1:0]    bounce_cnt_q, bounce_cnt_d;
    logic                   reject;
    logic                   busy;

    // Synchroniser chain; only its last stage is seen by the filter.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus_io.din};
        end
    end

    assign din_s = sync_q[SYNC_STAGES-1];

    // State and registered-output update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StStableLo;
            cnt_q        <= '0;
            q_q          <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            bounce_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            q_q          <= q_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            bounce_cnt_q <= bounce_cnt_d;
        end
    end

    // Next-state logic: qualify a candidate level for DEBOUNCE_CYCLES samples.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        reject  = 1'b0;

        unique case (state_q)
            StStableLo: begin
                if (din_s) begin
                    state_d = StChkHi;
                    cnt_d   = CntW'(1);
                end
            end
            StChkHi: begin
                if (!din_s) begin
                    state_d = StStableLo;
                    cnt_d   = '0;
                    reject  = 1'b1;
                end else if (cnt_q == CntLast) begin
                    state_d = StStableHi;
                    cnt_d   = '0;
                    q_d     = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStableHi: begin
                if (!din_s) begin
                    state_d = StChkLo;
                    cnt_d   = CntW'(1);
                end
            end
            StChkLo: begin
                if (din_s) begin
                    state_d = StStableHi;
                    cnt_d   = '0;
                    reject  = 1'b1;
                end else if (cnt_q == CntLast) begin
                    state_d = StStableLo;
                    cnt_d   = '0;
                    q_d     = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StStableLo;
                cnt_d   = '0;
            end
        endcase
    end

    // Rejected-candidate counter saturates rather than wrapping.
    always_comb begin
        bounce_cnt_d = bounce_cnt_q;
        if (reject && (bounce_cnt_q != {BOUNCE_W{1'b1}})) begin
            bounce_cnt_d = bounce_cnt_q + BOUNCE_W'(1);
        end
    end

    // Output decode: busy straight from the registered state.
    always_comb begin
        busy = (state_q == StChkHi) || (state_q == StChkLo);
    end

    assign bus_io.q          = q_q;
    assign bus_io.rise       = rise_q;
    assign bus_io.fall       = fall_q;
    assign bus_io.busy       = busy;
    assign bus_io.bounce_cnt = bounce_cnt_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync with default parameters.
module tb_debounce_sync;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    debounce_sync_if #(.BOUNCE_W(8)) dbi ();

    debounce_sync #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .BOUNCE_W       (8)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus_io(dbi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        dbi.din = 1'b1;
        tick();
        tick();
        n_checks++;
        if (dbi.q !== 1'b0 || dbi.busy !== 1'b0 || dbi.bounce_cnt !== 8'd0 ||
            dbi.rise !== 1'b0 || dbi.fall !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: q=%b busy=%b cnt=%0d rise=%b fall=%b, want all 0",
                     dbi.q, dbi.busy, dbi.bounce_cnt, dbi.rise, dbi.fall);
        end
        reset = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            n_checks++;
            if (dbi.q !== (i >= 6) || dbi.rise !== (i == 6)) begin
                n_errors++;
                $display("FAIL reset_release edge %0d: q=%b rise=%b, want q=%b rise=%b",
                         i, dbi.q, dbi.rise, (i >= 6), (i == 6));
            end
        end
    endtask

    task automatic test_rise();
        reset   = 1'b1;
        dbi.din = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        tick();
        dbi.din = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            n_checks++;
            if (dbi.busy !== (i >= 3 && i <= 5) || dbi.q !== (i >= 6) ||
                dbi.rise !== (i == 6) || dbi.fall !== 1'b0) begin
                n_errors++;
                $display("FAIL rise edge %0d: busy=%b q=%b rise=%b fall=%b, want %b %b %b 0",
                         i, dbi.busy, dbi.q, dbi.rise, dbi.fall,
                         (i >= 3 && i <= 5), (i >= 6), (i == 6));
            end
        end
        // Return to low so later tests start from q=0.
        dbi.din = 1'b0;
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_bounce();
        logic saw_rise;
        saw_rise = 1'b0;
        dbi.din  = 1'b1;
        tick();
        tick();
        dbi.din = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (dbi.rise === 1'b1 || dbi.q !== 1'b0) saw_rise = 1'b1;
        end
        n_checks++;
        if (saw_rise !== 1'b0) begin
            n_errors++;
            $display("FAIL bounce_filtered: q or rise went high, want q=0 rise=0");
        end
        n_checks++;
        if (dbi.bounce_cnt !== 8'd1) begin
            n_errors++;
            $display("FAIL bounce_count: got %0d, want 1", dbi.bounce_cnt);
        end
    endtask

    task automatic test_fall();
        dbi.din = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        n_checks++;
        if (dbi.q !== 1'b1) begin
            n_errors++;
            $display("FAIL fall_setup: q=%b, want 1", dbi.q);
        end
        dbi.din = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            n_checks++;
            if (dbi.busy !== (i >= 3 && i <= 5) || dbi.q !== (i < 6) ||
                dbi.fall !== (i == 6) || dbi.rise !== 1'b0) begin
                n_errors++;
                $display("FAIL fall edge %0d: busy=%b q=%b fall=%b rise=%b, want %b %b %b 0",
                         i, dbi.busy, dbi.q, dbi.fall, dbi.rise,
                         (i >= 3 && i <= 5), (i < 6), (i == 6));
            end
        end
        n_checks++;
        if (dbi.bounce_cnt !== 8'd1) begin
            n_errors++;
            $display("FAIL fall_count: got %0d, want 1", dbi.bounce_cnt);
        end
    endtask

    task automatic test_reset_mid();
        dbi.din = 1'b1;
        tick();
        tick();
        tick();
        n_checks++;
        if (dbi.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL midq_busy: busy=%b, want 1", dbi.busy);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (dbi.busy !== 1'b0 || dbi.q !== 1'b0 || dbi.bounce_cnt !== 8'd0 ||
            dbi.rise !== 1'b0) begin
            n_errors++;
            $display("FAIL midq_reset: busy=%b q=%b cnt=%0d rise=%b, want 0 0 0 0",
                     dbi.busy, dbi.q, dbi.bounce_cnt, dbi.rise);
        end
        reset   = 1'b0;
        dbi.din = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            n_checks++;
            if (dbi.busy !== 1'b0 || dbi.q !== 1'b0 || dbi.rise !== 1'b0) begin
                n_errors++;
                $display("FAIL midq_after edge %0d: busy=%b q=%b rise=%b, want 0 0 0",
                         i, dbi.busy, dbi.q, dbi.rise);
            end
        end
    endtask

    // Toggling din every cycle gives one-sample din_s pulses, each rejected.
    task automatic pulse_train(input int n, output logic bad);
        bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            dbi.din = 1'b1;
            tick();
            if (dbi.q !== 1'b0 || dbi.rise !== 1'b0) bad = 1'b1;
            dbi.din = 1'b0;
            tick();
            if (dbi.q !== 1'b0 || dbi.rise !== 1'b0) bad = 1'b1;
        end
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_saturation();
        logic bad;
        pulse_train(100, bad);
        n_checks++;
        if (dbi.bounce_cnt !== 8'd100) begin
            n_errors++;
            $display("FAIL sat_partial: got %0d, want 100", dbi.bounce_cnt);
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_errors++;
            $display("FAIL sat_q_partial: q or rise asserted, want 0");
        end
        pulse_train(200, bad);
        n_checks++;
        if (dbi.bounce_cnt !== 8'd255) begin
            n_errors++;
            $display("FAIL sat_hold: got %0d, want 255", dbi.bounce_cnt);
        end
        n_checks++;
        if (bad !== 1'b0 || dbi.q !== 1'b0) begin
            n_errors++;
            $display("FAIL sat_q: q=%b or pulse seen, want q=0", dbi.q);
        end
        pulse_train(1, bad);
        n_checks++;
        if (dbi.bounce_cnt !== 8'd255) begin
            n_errors++;
            $display("FAIL sat_extra: got %0d, want 255", dbi.bounce_cnt);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        dbi.din  = 1'b0;
        test_reset();
        test_rise();
        test_bounce();
        test_fall();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
